muldiv_issue: RTL and testbench
===============================

# muldiv_issue

EX-stage issue and write-back controller for the multi-cycle multiplier and divider. It decodes MULT/MULTU/DIV/DIVU/MTHI/MTLO, latches the operands and holds them stable for the whole operation. It launches the multiplier (start pulse, 64-bit result, ready pulse) or the divider, stalls the pipeline, and writes the 64-bit result into the architectural HI/LO registers. It also handles exception flushes and discards in-flight results.

## Interface
Parameters:
- DIVZERO_SKIP, 1, when 1 a DIV/DIVU with rt==0 bypasses the divider and leaves HI/LO unchanged.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- op_valid_i  in  1  EX instruction valid
- op_i  in  3  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 none
- rs_i, rt_i  in  32  source operands (forwarded)
- flush_i  in  1  exception/pipeline flush
- mul_start_o  out  1  one-cycle start pulse to multiplier
- mul_signed_o  out  1  signed select, held for whole operation
- mul_a_o, mul_b_o  out  32  multiplier operands, held for whole operation
- mul_result_i  in  64  product {hi,lo}
- mul_ready_i  in  1  one-cycle result-valid pulse
- div_start_o  out  1  one-cycle start pulse to divider
- div_signed_o  out  1  signed select, held
- div_a_o, div_b_o  out  32  dividend, divisor, held
- div_result_i  in  64  {remainder, quotient}
- div_ready_i  in  1  one-cycle result-valid pulse
- div_annul_o  out  1  one-cycle abort pulse to divider
- stall_o  out  1  freeze IF..EX
- hi_o, lo_o  out  32  architectural HI/LO

## Operation
- States: IDLE, MUL_BUSY, DIV_BUSY, DONE, MUL_DRAIN.
- Issue condition: `issue = op_valid_i & !flush_i & state==IDLE`.
- IDLE:
  - issue with MULT/MULTU: latch rs→mul_a_o and rt→mul_b_o; mul_signed_o=(op==MULT); mul_start_o=1 next cycle; go to MUL_BUSY.
  - issue with DIV/DIVU and rt!=0 (or DIVZERO_SKIP=0): latch into div_*; div_start_o=1 next cycle; go to DIV_BUSY.
  - issue with DIV/DIVU, rt==0 and DIVZERO_SKIP=1: go to DONE; no start; HI/LO unchanged.
  - issue with MTHI/MTLO: write hi_o/lo_o ←rs at the clock edge; stay in IDLE; no stall.
- MUL_BUSY: on mul_ready_i, hi_o←mul_result_i[63:32], lo_o←mul_result_i[31:0], go to DONE.
- DIV_BUSY: on div_ready_i, hi_o←div_result_i[63:32], lo_o←div_result_i[31:0], go to DONE.
- DONE: stall_o=0 for one cycle so the instruction leaves EX without re-issue; go to IDLE unconditionally.
- Operand hold: mul_*/div_* operand and signed outputs change only on issue. The multiplier re-samples signs during its final cycle, so these outputs must stay constant from issue until the state leaves BUSY.
- Flush:
  - In MUL_BUSY: go to MUL_DRAIN; no HI/LO write.
  - In MUL_DRAIN: wait for mul_ready_i, discard the result, then go to IDLE.
  - In DIV_BUSY: pulse div_annul_o for one cycle and go to IDLE; a div_ready_i in the same cycle is discarded.
  - In DONE or IDLE: no effect; suppresses issue and MTHI/MTLO.
- A result ready pulse in IDLE or DONE is ignored.

## Timing
- Reset values: stall_o=0, mul_start_o=0, div_start_o=0, div_annul_o=0, all operand/signed outputs 0, hi_o=lo_o=0. State goes to IDLE. Reset mid-operation discards everything; the multiplier shares rst.
- stall_o is combinational: `(state==IDLE & op_valid_i & !flush_i & op∈{1..4}) | state∈{MUL_BUSY,DIV_BUSY} | (state==MUL_DRAIN & op_valid_i & op∈{1..6})`; forced 0 while rst.
- Multiply sequence (issue cycle T):
  - mul_start_o high in T+1 only.
  - With the 3-state multiplier, mul_ready_i arrives in T+4.
  - HI/LO are written at the end of T+4 and are visible on hi_o/lo_o from T+5 (DONE, stall_o=0).
  - Stall spans T..T+4 (5 cycles).
- General multiply/divide latency: stall cycles = 1 + (cycles from start to ready) + 1.
- Divide by zero (skip): stall only in T; DONE in T+1.
- MTHI/MTLO: value visible at T+1; zero stall.
- No result forwarding: MFHI/MFLO read hi_o/lo_o, and those are valid in the DONE cycle.

## Test plan
- MULT rs=0xFFFFFFFE, rt=3, behavioural multiplier with 3-cycle latency → mul_start_o pulse at T+1, mul_signed_o=1, operands stable through T+4, stall_o high T..T+4, hi_o=0xFFFFFFFF and lo_o=0xFFFFFFFA at T+5.
- MULTU with the same operands → mul_signed_o=0, hi_o=0x00000002, lo_o=0xFFFFFFFA; op_valid_i held in DONE → no second mul_start_o.
- DIVU 100/7 with a 33-cycle divider model → div_start_o at T+1, stall until ready, then hi_o=2, lo_o=14. Also DIV rt=0 with DIVZERO_SKIP=1 → no div_start_o, stall 1 cycle, HI/LO unchanged.
- MULT issued, flush_i in the second MUL_BUSY cycle, new MULT presented → MUL_DRAIN stalls the new op, the stale mul_ready_i is discarded with HI/LO unchanged, and the new op issues the cycle after the drain completes.
- DIV in flight, flush_i asserted → div_annul_o one-cycle pulse, state IDLE next cycle, simultaneous div_ready_i discarded.
- MTHI rs=0x12345678 → hi_o=0x12345678 at T+1 with no stall. MTLO with flush_i=1 in the same cycle → lo_o unchanged. rst asserted mid-MUL_BUSY → all outputs return to reset values next cycle.

Source files
------------

// File: rtl/muldiv_issue.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_issue
// Purpose  : EX-stage issue / write-back controller for the multi-cycle
//            multiplier and divider. Latches operands, launches the unit,
//            stalls the pipeline and commits the 64-bit result to HI/LO.
//            Flushes drain (multiplier) or annul (divider) in-flight work.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_issue #(
  parameter bit DIVZERO_SKIP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  input  logic        flush_i,
  output logic        mul_start_o,
  output logic        mul_signed_o,
  output logic [31:0] mul_a_o,
  output logic [31:0] mul_b_o,
  input  logic [63:0] mul_result_i,
  input  logic        mul_ready_i,
  output logic        div_start_o,
  output logic        div_signed_o,
  output logic [31:0] div_a_o,
  output logic [31:0] div_b_o,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic        div_annul_o,
  output logic        stall_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  localparam logic [2:0] c_IDLE      = 3'd0;
  localparam logic [2:0] c_MUL_BUSY  = 3'd1;
  localparam logic [2:0] c_DIV_BUSY  = 3'd2;
  localparam logic [2:0] c_DONE      = 3'd3;
  localparam logic [2:0] c_MUL_DRAIN = 3'd4;

  localparam logic [2:0] c_OP_MULT  = 3'd1;
  localparam logic [2:0] c_OP_MULTU = 3'd2;
  localparam logic [2:0] c_OP_DIV   = 3'd3;
  localparam logic [2:0] c_OP_DIVU  = 3'd4;
  localparam logic [2:0] c_OP_MTHI  = 3'd5;
  localparam logic [2:0] c_OP_MTLO  = 3'd6;

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic        r_mul_start;
  logic        r_mul_signed;
  logic [31:0] r_mul_a;
  logic [31:0] r_mul_b;
  logic        r_div_start;
  logic        r_div_signed;
  logic [31:0] r_div_a;
  logic [31:0] r_div_b;
  logic        r_div_annul;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        w_stall;

  logic w_issue;
  logic w_is_mul;
  logic w_is_div;
  logic w_div_skip;
  logic w_muldiv_op;
  logic w_any_op;

  assign w_issue     = op_valid_i & ~flush_i & (r_state == c_IDLE);
  assign w_is_mul    = (op_i == c_OP_MULT) | (op_i == c_OP_MULTU);
  assign w_is_div    = (op_i == c_OP_DIV)  | (op_i == c_OP_DIVU);
  // A zero divisor never reaches the divider when skipping is enabled
  assign w_div_skip  = DIVZERO_SKIP & (rt_i == 32'd0);
  assign w_muldiv_op = w_is_mul | w_is_div;
  assign w_any_op    = w_muldiv_op | (op_i == c_OP_MTHI) | (op_i == c_OP_MTLO);

  // Next-state selection; flush takes priority over a coincident ready pulse
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_issue && w_is_mul) begin
          w_next = c_MUL_BUSY;
        end else if (w_issue && w_is_div) begin
          w_next = w_div_skip ? c_DONE : c_DIV_BUSY;
        end
      end
      c_MUL_BUSY: begin
        // A ready arriving with the flush completes the drain at once
        if (flush_i) begin
          w_next = mul_ready_i ? c_IDLE : c_MUL_DRAIN;
        end else if (mul_ready_i) begin
          w_next = c_DONE;
        end
      end
      c_DIV_BUSY: begin
        if (flush_i) begin
          w_next = c_IDLE;
        end else if (div_ready_i) begin
          w_next = c_DONE;
        end
      end
      c_DONE:      w_next = c_IDLE;
      c_MUL_DRAIN: if (mul_ready_i) w_next = c_IDLE;
      default:     w_next = c_IDLE;
    endcase
  end

  // Pipeline freeze request, held low during reset
  always_comb begin
    w_stall = 1'b0;
    if (!rst) begin
      case (r_state)
        c_IDLE:      w_stall = op_valid_i & ~flush_i & w_muldiv_op;
        c_MUL_BUSY:  w_stall = 1'b1;
        c_DIV_BUSY:  w_stall = 1'b1;
        c_MUL_DRAIN: w_stall = op_valid_i & w_any_op;
        default:     w_stall = 1'b0;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_next;
  end

  // Unit launch: start/annul pulses and operands that stay frozen until the next issue
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mul_start  <= 1'b0;
      r_mul_signed <= 1'b0;
      r_mul_a      <= 32'd0;
      r_mul_b      <= 32'd0;
      r_div_start  <= 1'b0;
      r_div_signed <= 1'b0;
      r_div_a      <= 32'd0;
      r_div_b      <= 32'd0;
      r_div_annul  <= 1'b0;
    end else begin
      r_mul_start <= w_issue & w_is_mul;
      r_div_start <= w_issue & w_is_div & ~w_div_skip;
      r_div_annul <= (r_state == c_DIV_BUSY) & flush_i;
      if (w_issue && w_is_mul) begin
        r_mul_a      <= rs_i;
        r_mul_b      <= rt_i;
        r_mul_signed <= (op_i == c_OP_MULT);
      end
      if (w_issue && w_is_div && !w_div_skip) begin
        r_div_a      <= rs_i;
        r_div_b      <= rt_i;
        r_div_signed <= (op_i == c_OP_DIV);
      end
    end
  end

  // Architectural HI/LO: direct moves on issue, unit results only when not flushed
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else begin
      if (w_issue && op_i == c_OP_MTHI) r_hi <= rs_i;
      if (w_issue && op_i == c_OP_MTLO) r_lo <= rs_i;
      if (r_state == c_MUL_BUSY && !flush_i && mul_ready_i) begin
        r_hi <= mul_result_i[63:32];
        r_lo <= mul_result_i[31:0];
      end
      if (r_state == c_DIV_BUSY && !flush_i && div_ready_i) begin
        r_hi <= div_result_i[63:32];
        r_lo <= div_result_i[31:0];
      end
    end
  end

  assign mul_start_o  = r_mul_start;
  assign mul_signed_o = r_mul_signed;
  assign mul_a_o      = r_mul_a;
  assign mul_b_o      = r_mul_b;
  assign div_start_o  = r_div_start;
  assign div_signed_o = r_div_signed;
  assign div_a_o      = r_div_a;
  assign div_b_o      = r_div_b;
  assign div_annul_o  = r_div_annul;
  assign stall_o      = w_stall;
  assign hi_o         = r_hi;
  assign lo_o         = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_issue
// Purpose  : Self-checking bench for muldiv_issue with behavioural
//            multiplier (3-cycle) and divider (33-cycle) models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_issue;

  localparam bit DIVZERO_SKIP = 1'b1;
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 33;

  logic        clk;
  logic        rst;
  logic        op_valid_i;
  logic [2:0]  op_i;
  logic [31:0] rs_i, rt_i;
  logic        flush_i;
  logic        mul_start_o, mul_signed_o;
  logic [31:0] mul_a_o, mul_b_o;
  logic [63:0] mul_result_i;
  logic        mul_ready_i;
  logic        div_start_o, div_signed_o;
  logic [31:0] div_a_o, div_b_o;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic        div_annul_o;
  logic        stall_o;
  logic [31:0] hi_o, lo_o;

  muldiv_issue #(.DIVZERO_SKIP(DIVZERO_SKIP)) dut (
    .clk(clk), .rst(rst), .op_valid_i(op_valid_i), .op_i(op_i),
    .rs_i(rs_i), .rt_i(rt_i), .flush_i(flush_i),
    .mul_start_o(mul_start_o), .mul_signed_o(mul_signed_o),
    .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
    .mul_result_i(mul_result_i), .mul_ready_i(mul_ready_i),
    .div_start_o(div_start_o), .div_signed_o(div_signed_o),
    .div_a_o(div_a_o), .div_b_o(div_b_o),
    .div_result_i(div_result_i), .div_ready_i(div_ready_i),
    .div_annul_o(div_annul_o), .stall_o(stall_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference architectural state
  logic [31:0] m_hi, m_lo;

  // Unit model state
  int          mcnt, dcnt;
  logic [31:0] mm_a, mm_b, dd_a, dd_b;
  logic        mm_s, dd_s;

  function automatic logic [63:0] mul_calc(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb;
    logic [63:0] p;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = 64'(sa * sb);
    end else begin
      p = {32'd0, a} * {32'd0, b};
    end
    return p;
  endfunction

  // Returns {remainder, quotient}
  function automatic logic [63:0] div_calc(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, q, r;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural multiplier and divider, advanced once per cycle
  task automatic model_update();
    if (rst) begin
      mcnt = 0; dcnt = 0;
      mul_ready_i = 1'b0; div_ready_i = 1'b0;
    end else begin
      mul_ready_i = 1'b0;
      div_ready_i = 1'b0;
      if (mcnt > 0) begin
        mcnt--;
        if (mcnt == 0) begin
          mul_ready_i  = 1'b1;
          mul_result_i = mul_calc(mm_a, mm_b, mm_s);
        end
      end
      if (mul_start_o === 1'b1) begin
        mcnt = MUL_LAT; mm_a = mul_a_o; mm_b = mul_b_o; mm_s = mul_signed_o;
      end
      if (div_annul_o === 1'b1) begin
        dcnt = 0;
      end else if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) begin
          div_ready_i  = 1'b1;
          div_result_i = div_calc(dd_a, dd_b, dd_s);
        end
      end
      if (div_start_o === 1'b1) begin
        dcnt = DIV_LAT; dd_a = div_a_o; dd_b = div_b_o; dd_s = div_signed_o;
      end
    end
  endtask

  // Advance one clock; models drive at +1, test code at +2, sampling at +3
  task automatic tick();
    @(posedge clk);
    #1;
    model_update();
    #1;
  endtask

  // Present one instruction, hold it while stalled, and check the whole transaction
  task automatic run_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    logic [31:0] ehi, elo, hi_leave, lo_leave;
    logic [63:0] r64;
    int exp_stall, exp_m, exp_d;
    int stalls, mstarts, dstarts, mfirst, dfirst;
    logic bad_hold, s;
    ehi = m_hi; elo = m_lo;
    exp_stall = 0; exp_m = 0; exp_d = 0;
    case (op)
      3'd1, 3'd2: begin
        r64 = mul_calc(rs, rt, op == 3'd1);
        ehi = r64[63:32]; elo = r64[31:0];
        exp_stall = 2 + MUL_LAT; exp_m = 1;
      end
      3'd3, 3'd4: begin
        if (rt == 32'd0 && DIVZERO_SKIP) begin
          exp_stall = 1;
        end else begin
          r64 = div_calc(rs, rt, op == 3'd3);
          ehi = r64[63:32]; elo = r64[31:0];
          exp_stall = 2 + DIV_LAT; exp_d = 1;
        end
      end
      3'd5: ehi = rs;
      3'd6: elo = rs;
      default: ;
    endcase
    stalls = 0; mstarts = 0; dstarts = 0; mfirst = -1; dfirst = -1;
    bad_hold = 1'b0; hi_leave = '0; lo_leave = '0;
    for (int n = 0; n < 100; n++) begin
      op_valid_i = 1'b1; op_i = op; rs_i = rs; rt_i = rt; flush_i = 1'b0;
      #1;
      if (mul_start_o === 1'b1) begin mstarts++; if (mfirst < 0) mfirst = n; end
      if (div_start_o === 1'b1) begin dstarts++; if (dfirst < 0) dfirst = n; end
      if (n > 0 && exp_m == 1 &&
          (mul_a_o !== rs || mul_b_o !== rt || mul_signed_o !== (op == 3'd1))) bad_hold = 1'b1;
      if (n > 0 && exp_d == 1 &&
          (div_a_o !== rs || div_b_o !== rt || div_signed_o !== (op == 3'd3))) bad_hold = 1'b1;
      s = stall_o;
      if (s === 1'b1) stalls++;
      else begin hi_leave = hi_o; lo_leave = lo_o; end
      tick();
      if (s !== 1'b1) break;
    end
    op_valid_i = 1'b0; op_i = 3'd0;
    for (int n = 0; n < 2; n++) begin
      #1;
      if (mul_start_o === 1'b1) mstarts++;
      if (div_start_o === 1'b1) dstarts++;
      tick();
    end
    check($sformatf("stall_cycles op%0d", op), stalls, exp_stall);
    check($sformatf("mul_starts op%0d", op), mstarts, exp_m);
    check($sformatf("div_starts op%0d", op), dstarts, exp_d);
    if (exp_m == 1) check("mul_start_cycle", mfirst, 1);
    if (exp_d == 1) check("div_start_cycle", dfirst, 1);
    if (exp_m == 1 || exp_d == 1) begin
      check("operand_hold", bad_hold, 1'b0);
      check($sformatf("hilo_in_done op%0d", op), {hi_leave, lo_leave}, {ehi, elo});
    end
    check($sformatf("hilo_after op%0d", op), {hi_o, lo_o}, {ehi, elo});
    m_hi = ehi; m_lo = elo;
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] rrs, rrt;
    rst = 1'b1; op_valid_i = 1'b0; op_i = 3'd0; rs_i = '0; rt_i = '0; flush_i = 1'b0;
    mul_result_i = '0; mul_ready_i = 1'b0; div_result_i = '0; div_ready_i = 1'b0;
    mcnt = 0; dcnt = 0; mm_a = '0; mm_b = '0; dd_a = '0; dd_b = '0; mm_s = 1'b0; dd_s = 1'b0;
    m_hi = '0; m_lo = '0;
    tick(); tick();

    // Reset values, stall forced low while reset even with a multiply presented
    op_valid_i = 1'b1; op_i = 3'd1;
    #1;
    check("reset_stall", stall_o, 1'b0);
    check("reset_pulses", {mul_start_o, div_start_o, div_annul_o}, 3'b000);
    check("reset_ops", {mul_signed_o, div_signed_o, mul_a_o, mul_b_o, div_a_o, div_b_o}, '0);
    check("reset_hilo", {hi_o, lo_o}, 64'd0);
    op_valid_i = 1'b0; op_i = 3'd0; rst = 1'b0;
    tick();

    // Directed arithmetic cases with literal results
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3);
    check("mult_lit", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op(3'd2, 32'hFFFF_FFFE, 32'd3);
    check("multu_lit", {hi_o, lo_o}, 64'h0000_0002_FFFF_FFFA);
    run_op(3'd4, 32'd100, 32'd7);
    check("divu_lit", {hi_o, lo_o}, {32'd2, 32'd14});
    run_op(3'd3, 32'd55, 32'd0);
    check("divzero_lit", {hi_o, lo_o}, {32'd2, 32'd14});
    run_op(3'd5, 32'h1234_5678, 32'd0);
    check("mthi_lit", hi_o, 32'h1234_5678);

    // MTLO with flush is suppressed; ready pulses in IDLE are ignored
    op_valid_i = 1'b1; op_i = 3'd6; rs_i = 32'hBAD0_BAD0; flush_i = 1'b1;
    #1;
    check("mtlo_flush_stall", stall_o, 1'b0);
    tick();
    op_valid_i = 1'b0; op_i = 3'd0; flush_i = 1'b0;
    mul_ready_i = 1'b1; mul_result_i = 64'hDEAD_BEEF_CAFE_F00D;
    div_ready_i = 1'b1; div_result_i = 64'hFEED_FACE_0BAD_F00D;
    #1;
    check("mtlo_flush_lo", lo_o, m_lo);
    tick();
    #1;
    check("idle_ready_ignored", {hi_o, lo_o}, {m_hi, m_lo});
    tick();

    // Flush in the second MUL_BUSY cycle, then a new multiply waits out the drain
    op_valid_i = 1'b1; op_i = 3'd1; rs_i = 32'h0000_1234; rt_i = 32'h10;
    tick();
    op_valid_i = 1'b0;
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    op_valid_i = 1'b1; op_i = 3'd2; rs_i = 32'h8000_0001; rt_i = 32'h0000_0005;
    #1;
    check("drain_stall_a", {stall_o, mul_start_o}, 2'b10);
    tick();
    #1;
    check("drain_stall_b", {stall_o, mul_start_o}, 2'b10);
    tick();
    check("drain_discard", {hi_o, lo_o}, {m_hi, m_lo});
    run_op(3'd2, 32'h8000_0001, 32'h0000_0005);

    // Flush while the divider is busy: annul pulse, IDLE next cycle, coincident ready dropped
    op_valid_i = 1'b1; op_i = 3'd4; rs_i = 32'd100; rt_i = 32'd7;
    tick();
    op_valid_i = 1'b0; op_i = 3'd0;
    tick();
    tick();
    flush_i = 1'b1; div_ready_i = 1'b1; div_result_i = 64'hDEAD_DEAD_DEAD_DEAD;
    #1;
    check("div_flush_cycle", {stall_o, div_annul_o}, 2'b10);
    tick();
    flush_i = 1'b0;
    op_valid_i = 1'b1; op_i = 3'd6; rs_i = 32'hA5A5_0001;
    #1;
    check("div_annul_pulse", {stall_o, div_annul_o}, 2'b01);
    tick();
    op_valid_i = 1'b0; op_i = 3'd0;
    #1;
    check("div_annul_end", div_annul_o, 1'b0);
    check("div_flush_hilo", {hi_o, lo_o}, {m_hi, 32'hA5A5_0001});
    m_lo = 32'hA5A5_0001;
    tick();

    // Randomized instruction stream
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      rrs = $urandom;
      case ($urandom_range(0, 5))
        0:       rrt = 32'd0;
        1, 2:    rrt = 32'($urandom_range(1, 20));
        default: rrt = $urandom;
      endcase
      run_op(rop, rrs, rrt);
    end

    // Reset in the middle of a multiply
    run_op(3'd5, 32'h0F0F_0F0F, 32'd0);
    op_valid_i = 1'b1; op_i = 3'd1; rs_i = 32'd3; rt_i = 32'd4;
    tick();
    op_valid_i = 1'b0; op_i = 3'd0;
    tick();
    rst = 1'b1;
    #1;
    check("rst_stall_forced", stall_o, 1'b0);
    tick();
    #1;
    check("rst_mid_hilo", {hi_o, lo_o}, 64'd0);
    check("rst_mid_ops", {mul_signed_o, div_signed_o, mul_a_o, mul_b_o, div_a_o, div_b_o}, '0);
    check("rst_mid_ctrl", {stall_o, mul_start_o, div_start_o, div_annul_o}, 4'b0000);
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    tick();
    run_op(3'd6, 32'h7777_0000, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
